// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receive-state encoding and default sizing.
package uart_pkg;
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        PUSH  = 3'd4,
        BREAK = 3'd5
    } rx_state_e;
    localparam int SAMPLE_RATE_DEF = 16;
    localparam int MID_SAMPLE = 7;
    localparam int DATA_W_DEF = 16;
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: one-clk tick every max(baud_divisor,1) clks while enabled, held at zero otherwise.
module uart_baud_tick #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [DIV_W-1:0] baud_divisor,
    output logic             tick
);
    logic [DIV_W-1:0] cnt_q, cnt_d, lim_q, lim_d;
    always_comb begin
        tick = enable && (cnt_q == lim_q);
        cnt_d = (!enable || tick) ? '0 : cnt_q + 1'b1;
        // The period is latched only on reload, so divisor changes never cut a tick short.
        lim_d = (!enable || tick) ? ((baud_divisor > DIV_W'(1)) ? baud_divisor - 1'b1 : '0) : lim_q;
    end
    always_ff @(posedge clk) begin
        cnt_q <= rst ? '0 : cnt_d;
        lim_q <= rst ? '0 : lim_d;
    end
endmodule

// File: rtl/uart_rx_word.sv
// uart_rx_word: 16x-oversampled UART receiver pushing each good word into the RX FIFO.
// Build option UART_RX_MAJORITY_EN: 2-of-3 majority of ticks 7/8/9 per bit instead of a single tick-7 sample.
module uart_rx_word
    import uart_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int SAMPLE_RATE = SAMPLE_RATE_DEF,
    parameter int DIV_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DIV_W-1:0]  baud_divisor,
    input  logic              rx,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_fifo_en,
    input  logic              rx_full,
    output logic [2:0]        state,
    output logic              frame_err,
    output logic              overrun
);
    localparam int SW = $clog2(SAMPLE_RATE);
    localparam int BW = $clog2(DATA_W + 1);
    localparam logic [SW-1:0] SAMP_LAST = SW'(SAMPLE_RATE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
`ifdef UART_RX_MAJORITY_EN
    localparam logic [SW-1:0] START_LAST = SW'(MID_SAMPLE + 2);
`else
    localparam logic [SW-1:0] START_LAST = SW'(MID_SAMPLE);
`endif
    rx_state_e         state_q, state_d;
    logic [1:0]        sync_q;
    logic [SW-1:0]     samp_q, samp_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d, rx_data_q, rx_data_d;
    logic              fifo_en_q, fifo_en_d, ferr_q, ferr_d, ovr_q, ovr_d;
    logic              rx_s, tick, bit_v;
    assign rx_s = sync_q[1];
    uart_baud_tick #(.DIV_W(DIV_W)) u_tick (
        .clk          (clk),
        .rst          (rst),
        .enable       (state_q != IDLE),
        .baud_divisor (baud_divisor),
        .tick         (tick)
    );
`ifdef UART_RX_MAJORITY_EN
    // Holds rx_s from the two ticks preceding each decision tick.
    logic [1:0] maj_q;
    always_ff @(posedge clk) maj_q <= rst ? 2'b11 : (tick ? {maj_q[0], rx_s} : maj_q);
    assign bit_v = (maj_q[1] & maj_q[0]) | (maj_q[1] & rx_s) | (maj_q[0] & rx_s);
`else
    assign bit_v = rx_s;
`endif
    always_comb begin
        state_d = state_q;
        samp_d = tick ? samp_q + 1'b1 : samp_q;
        bit_d = bit_q;
        shift_d = shift_q;
        rx_data_d = rx_data_q;
        fifo_en_d = 1'b0;
        ferr_d = 1'b0;
        ovr_d = 1'b0;
        case (state_q)
            IDLE: begin
                samp_d = '0;
                bit_d = '0;
                state_d = rx_s ? IDLE : START;
            end
            START: if (tick && samp_q == START_LAST) begin
                samp_d = '0;
                state_d = bit_v ? IDLE : DATA;
            end
            DATA: if (tick && samp_q == SAMP_LAST) begin
                samp_d = '0;
                shift_d = {bit_v, shift_q[DATA_W-1:1]};
                bit_d = bit_q + 1'b1;
                state_d = (bit_q == BIT_LAST) ? STOP : DATA;
            end
            STOP: if (tick && samp_q == SAMP_LAST) begin
                samp_d = '0;
                ferr_d = !bit_v;
                state_d = bit_v ? PUSH : BREAK;
            end
            PUSH: begin
                fifo_en_d = !rx_full;
                ovr_d = rx_full;
                rx_data_d = rx_full ? rx_data_q : shift_q;
                state_d = IDLE;
            end
            BREAK: state_d = rx_s ? IDLE : BREAK;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b11;
            state_q <= IDLE;
            samp_q <= '0;
            bit_q <= '0;
            shift_q <= '0;
            rx_data_q <= '0;
            fifo_en_q <= 1'b0;
            ferr_q <= 1'b0;
            ovr_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], rx};
            state_q <= state_d;
            samp_q <= samp_d;
            bit_q <= bit_d;
            shift_q <= shift_d;
            rx_data_q <= rx_data_d;
            fifo_en_q <= fifo_en_d;
            ferr_q <= ferr_d;
            ovr_q <= ovr_d;
        end
    end
    assign rx_data = rx_data_q;
    assign rx_fifo_en = fifo_en_q;
    assign frame_err = ferr_q;
    assign overrun = ovr_q;
    assign state = state_q;
endmodule

// File: tb/tb_uart_rx_word.sv
// tb_uart_rx_word: directed frames with a queue scoreboard checked by an independent strobe monitor.
module tb_uart_rx_word;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx = 1'b1;
    logic        rx_full = 1'b0;
    logic [15:0] baud_divisor = 16'd27;
    logic [15:0] rx_data;
    logic        rx_fifo_en, frame_err, overrun;
    logic [2:0]  state;
    logic [15:0] exp_q[$];
    logic [15:0] exp_word;
    int checks = 0, errors = 0;
    int strobe_cnt = 0, ferr_cnt = 0, ovr_cnt = 0, exp_strobes = 0;

    uart_rx_word #(.DATA_W(16), .SAMPLE_RATE(16), .DIV_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .baud_divisor (baud_divisor),
        .rx           (rx),
        .rx_data      (rx_data),
        .rx_fifo_en   (rx_fifo_en),
        .rx_full      (rx_full),
        .state        (state),
        .frame_err    (frame_err),
        .overrun      (overrun)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (rx_fifo_en) begin
                strobe_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_strobe: rx_data=%h, expected no strobe", rx_data);
                end else begin
                    exp_word = exp_q.pop_front();
                    if (rx_data !== exp_word) begin
                        errors++;
                        $display("FAIL rx_data: got %h, expected %h", rx_data, exp_word);
                    end
                end
            end
            if (frame_err) ferr_cnt++;
            if (overrun) ovr_cnt++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic int bit_clks();
        return 16 * ((baud_divisor > 16'd1) ? int'(baud_divisor) : 1);
    endfunction

    task automatic expect_word(input logic [15:0] d);
        exp_q.push_back(d);
        exp_strobes++;
    endtask

    task automatic send_frame(input logic [15:0] d, input logic stop_bit);
        int n = bit_clks();
        rx = 1'b0;
        repeat (n) @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            rx = d[i];
            repeat (n) @(negedge clk);
        end
        rx = stop_bit;
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (state != 3'd0 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check(name, {29'd0, state}, 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_rx_data", {16'd0, rx_data}, 32'd0);
        check("reset_fifo_en", {31'd0, rx_fifo_en}, 32'd0);
        check("reset_state", {29'd0, state}, 32'd0);
        check("reset_frame_err", {31'd0, frame_err}, 32'd0);
        check("reset_overrun", {31'd0, overrun}, 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        expect_word(16'hA501);
        send_frame(16'hA501, 1'b1);
        repeat (8) @(negedge clk);
        check("single_strobes", strobe_cnt, 1);
        check("single_ferr", ferr_cnt, 0);
        check("single_ovr", ovr_cnt, 0);

        for (int i = 0; i < 4; i++) expect_word(16'hA500 + 16'(i));
        for (int i = 0; i < 4; i++) send_frame(16'hA500 + 16'(i), 1'b1);
        repeat (8) @(negedge clk);
        check("burst_strobes", strobe_cnt, 5);

        rx = 1'b0;
        repeat (100) @(negedge clk);
        rx = 1'b1;
        repeat (400) @(negedge clk);
        wait_idle("glitch_state");
        check("glitch_strobes", strobe_cnt, 5);
        check("glitch_ferr", ferr_cnt, 0);
        check("glitch_ovr", ovr_cnt, 0);

        baud_divisor = 16'd3;
        repeat (5) @(negedge clk);
        send_frame(16'h1234, 1'b0);
        repeat (2000) @(negedge clk);
        check("badstop_busy", {29'd0, state}, 32'd5);
        rx = 1'b1;
        repeat (5) @(negedge clk);
        wait_idle("badstop_state");
        check("badstop_ferr", ferr_cnt, 1);
        check("badstop_strobes", strobe_cnt, 5);
        expect_word(16'h5678);
        send_frame(16'h5678, 1'b1);
        repeat (8) @(negedge clk);
        check("after_badstop_strobes", strobe_cnt, 6);

        rx_full = 1'b1;
        send_frame(16'hBEEF, 1'b1);
        repeat (8) @(negedge clk);
        rx_full = 1'b0;
        check("full_ovr", ovr_cnt, 1);
        check("full_strobes", strobe_cnt, 6);
        check("full_data_held", {16'd0, rx_data}, 32'h5678);
        expect_word(16'hCAFE);
        send_frame(16'hCAFE, 1'b1);
        repeat (8) @(negedge clk);
        check("after_full_strobes", strobe_cnt, 7);

        rx = 1'b0;
        repeat (bit_clks()) @(negedge clk);
        rx = 1'b1;
        repeat (8 * bit_clks() + bit_clks() / 2) @(negedge clk);
        check("midframe_busy", {29'd0, state}, 32'd2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_state", {29'd0, state}, 32'd0);
        check("midrst_rx_data", {16'd0, rx_data}, 32'd0);
        repeat (9 * bit_clks()) @(negedge clk);
        check("midrst_idle", {29'd0, state}, 32'd0);
        check("midrst_strobes", strobe_cnt, 7);
        expect_word(16'h0001);
        send_frame(16'h0001, 1'b1);
        repeat (8) @(negedge clk);
        check("after_rst_strobes", strobe_cnt, 8);

        baud_divisor = 16'd0;
        repeat (5) @(negedge clk);
        expect_word(16'h8001);
        send_frame(16'h8001, 1'b1);
        baud_divisor = 16'd1;
        repeat (5) @(negedge clk);
        expect_word(16'h7FFE);
        send_frame(16'h7FFE, 1'b1);
        repeat (8) @(negedge clk);
        wait_idle("final_state");

        check("final_strobes", strobe_cnt, exp_strobes);
        check("final_queue_empty", exp_q.size(), 0);
        check("final_ferr", ferr_cnt, 1);
        check("final_ovr", ovr_cnt, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx_word.md
Name: uart_rx_word

Overview:
- Standalone receive side of the UART link: deserialises one 16-bit-payload frame from the `rx` line using 16x oversampling.
- Pushes each good word into the downstream RX FIFO with a single-cycle write strobe.
- Sits between the pad/loopback line and the RX FIFO write port. It is the consumer end for frames produced by the UART transmitter.
- Frame format: 1 start bit (0), DATA_W data bits LSB first, 1 stop bit (1), no parity.

Parameters:
- DATA_W, 16, payload bits per frame and FIFO word width
- SAMPLE_RATE, 16, oversampling ticks per bit period
- DIV_W, 16, width of baud_divisor

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- baud_divisor  in  DIV_W  clk cycles per sample tick; values 0 and 1 both mean a tick every clk
- rx  in  1  serial line, asynchronous, idles high
- rx_data  out  DATA_W  received word; valid while rx_fifo_en=1
- rx_fifo_en  out  1  FIFO write strobe, one clk per accepted word
- rx_full  in  1  FIFO full flag
- state  out  3  current FSM state encoding
- frame_err  out  1  one-clk pulse when the stop bit samples 0
- overrun  out  1  one-clk pulse when a good word is dropped because rx_full=1

Behaviour:
- Reset values: rx_data=0, rx_fifo_en=0, frame_err=0, overrun=0, state=IDLE, tick counter=0, sample counter=0, bit counter=0. Synchroniser flops reset to 1.
- rx passes through a 2-flop synchroniser. All decisions use the synchronised value rx_s.
- Tick generator: counts clk cycles and emits a one-clk tick every max(baud_divisor,1) cycles. It free-runs in all states except IDLE, where it is held at 0 so the first tick comes one full divisor after start detection.
- A baud_divisor change takes effect at the next tick-counter reload.
- FSM state encodings: IDLE=0, START=1, DATA=2, STOP=3, PUSH=4, BREAK=5.
- IDLE: when rx_s=0, go to START and clear the sample counter.
- START: counts ticks. At sample 7 (mid-bit):
  - rx_s=0: clear the sample counter, go to DATA.
  - rx_s=1: treat as a glitch and return to IDLE with no pulse.
- DATA: every SAMPLE_RATE ticks (bit centre), shift rx_s into the MSB of the shift register (LSB-first reassembly). After DATA_W samples, go to STOP.
- STOP: at the stop-bit centre:
  - rx_s=1: go to PUSH.
  - rx_s=0: pulse frame_err, discard the word, go to BREAK.
- BREAK: wait for rx_s=1, then go to IDLE. A held-low line produces exactly one frame_err.
- PUSH: lasts exactly one clk, then IDLE.
  - rx_full=0: rx_fifo_en=1 and rx_data=shift register.
  - rx_full=1: overrun=1, word dropped, rx_data unchanged.
- Latency: rx_fifo_en asserts 2 (synchroniser) + 1 clk after the stop-bit centre sample.
- A falling edge arriving during PUSH is caught in IDLE on the next clk, so back-to-back frames with no idle gap are received.
- rst asserted mid-frame: the frame is abandoned, all outputs return to reset values on the next clk, and no strobe or pulse is issued.
- A start detected while the FIFO is full is still received; the drop decision is made only in PUSH.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined: every bit decision (start check, data, stop) uses the 2-of-3 majority of rx_s at ticks 7, 8 and 9 within the bit. The state advances at tick 9 instead of 7, and latency grows by 2 ticks.
- Undefined: single sample at tick 7.
- Ports and encodings are identical in both builds.

Decomposition:
- Package uart_pkg holds:
  - rx_state_e enum (3-bit, encodings above)
  - SAMPLE_RATE_DEF=16
  - MID_SAMPLE=7
  - DATA_W_DEF=16
- Sub-module uart_baud_tick (clk, rst, enable, baud_divisor -> tick) is shared with the transmitter.

Test Plan:
- Base setup for all scenarios: 50 MHz clk, baud_divisor=27 (432 clk per bit), FIFO not full.
- Single word: drive frame 16'hA501 -> exactly one rx_fifo_en with rx_data=16'hA501; frame_err=0, overrun=0.
- Back-to-back burst: frames A500, A501, A502, A503 with no idle gap -> four strobes in order with matching data.
- Start glitch: rx low for 100 clk, then high -> no strobe, state back to 0, no error pulses.
- Bad stop: frame 16'h1234 with stop bit 0, line held low 2000 clk, then high -> one frame_err pulse, no strobe; the next frame 16'h5678 is received correctly.
- FIFO full: rx_full=1 during frame 16'hBEEF -> one overrun pulse, rx_fifo_en stays 0; after clearing rx_full, frame 16'hCAFE is written.
- Reset mid-frame: assert rst for 1 clk during data bit 8 of frame 16'hFFFF -> no strobe, state=0; the next frame 16'h0001 is received intact.
